// File: rtl/donation_allocator_if.sv
// Handshake, configuration and status bundle for donation_allocator.
// The master side drives donors, patient types and requests; the slave side is the allocator.
interface donation_allocator_if #(
    parameter int CNT_W = 8
);
    logic             cfg_we;
    logic [2:0]       cfg_idx;
    logic             cfg_a;
    logic             cfg_b;
    logic             cfg_rh;
    logic [7:0]       req_set;
    logic [7:0]       req_cancel;
    logic             donor_valid;
    logic             donor_a;
    logic             donor_b;
    logic             donor_rh;
    logic             donor_ready;
    logic             grant_valid;
    logic [2:0]       grant_idx;
    logic             nomatch;
    logic [7:0]       pending;
    logic [CNT_W-1:0] units_granted;

    modport master (
        output cfg_we, cfg_idx, cfg_a, cfg_b, cfg_rh,
        output req_set, req_cancel,
        output donor_valid, donor_a, donor_b, donor_rh,
        input  donor_ready, grant_valid, grant_idx, nomatch,
        input  pending, units_granted
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_a, cfg_b, cfg_rh,
        input  req_set, req_cancel,
        input  donor_valid, donor_a, donor_b, donor_rh,
        output donor_ready, grant_valid, grant_idx, nomatch,
        output pending, units_granted
    );
endinterface

// File: rtl/donation_allocator.sv
// Serial donor-to-patient blood unit allocator over eight pending requests.
// Define ALLOC_ROUND_ROBIN_EN to start each scan just below the last granted slot.
module donation_allocator #(
    parameter int NPAT  = 8,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    donation_allocator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, GRANT, NOMATCH} state_e;

    state_e           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [2:0]       gidx_q, gidx_d;
    logic [2:0]       start_idx;
    logic [NPAT-1:0]  pa_q, pa_d, pb_q, pb_d, prh_q, prh_d;
    logic [NPAT-1:0]  pend_q, pend_d, gclr;
    logic             da_q, da_d, db_q, db_d, drh_q, drh_d;
    logic             gv_q, gv_d, nm_q, nm_d;
    logic             hit;
    logic [CNT_W-1:0] units_q, units_d;

`ifdef ALLOC_ROUND_ROBIN_EN
    logic [2:0] last_q, last_d;
    assign start_idx = last_q - 3'd1;
`else
    assign start_idx = 3'd7;
`endif

    // A recipient must carry every antigen the donor unit carries.
    assign hit = pend_q[ptr_q]
               & (~da_q  | pa_q[ptr_q])
               & (~db_q  | pb_q[ptr_q])
               & (~drh_q | prh_q[ptr_q]);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gidx_d  = gidx_q;
        da_d    = da_q;
        db_d    = db_q;
        drh_d   = drh_q;
        gv_d    = 1'b0;
        nm_d    = 1'b0;
        units_d = units_q;
        gclr    = '0;
        pa_d    = pa_q;
        pb_d    = pb_q;
        prh_d   = prh_q;
`ifdef ALLOC_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.donor_valid) begin
                    da_d    = bus.donor_a;
                    db_d    = bus.donor_b;
                    drh_d   = bus.donor_rh;
                    ptr_d   = start_idx;
                    cnt_d   = 3'd0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (hit) begin
                    gidx_d  = ptr_q;
                    gv_d    = 1'b1;
                    state_d = GRANT;
                end else begin
                    ptr_d = ptr_q - 3'd1;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        nm_d    = 1'b1;
                        state_d = NOMATCH;
                    end
                end
            end
            GRANT: begin
                gclr[gidx_q] = 1'b1;
                if (units_q != {CNT_W{1'b1}}) begin
                    units_d = units_q + CNT_W'(1);
                end
`ifdef ALLOC_ROUND_ROBIN_EN
                last_d = gidx_q;
`endif
                state_d = IDLE;
            end
            NOMATCH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.cfg_we) begin
            pa_d[bus.cfg_idx]  = bus.cfg_a;
            pb_d[bus.cfg_idx]  = bus.cfg_b;
            prh_d[bus.cfg_idx] = bus.cfg_rh;
        end
        // Cancel beats set, set beats the grant's own clear.
        pend_d = ((pend_q & ~gclr) | bus.req_set) & ~bus.req_cancel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            cnt_q   <= 3'd0;
            gidx_q  <= 3'd0;
            da_q    <= 1'b0;
            db_q    <= 1'b0;
            drh_q   <= 1'b0;
            gv_q    <= 1'b0;
            nm_q    <= 1'b0;
            units_q <= '0;
            pa_q    <= '0;
            pb_q    <= '0;
            prh_q   <= '0;
            pend_q  <= '0;
`ifdef ALLOC_ROUND_ROBIN_EN
            last_q  <= 3'd0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gidx_q  <= gidx_d;
            da_q    <= da_d;
            db_q    <= db_d;
            drh_q   <= drh_d;
            gv_q    <= gv_d;
            nm_q    <= nm_d;
            units_q <= units_d;
            pa_q    <= pa_d;
            pb_q    <= pb_d;
            prh_q   <= prh_d;
            pend_q  <= pend_d;
`ifdef ALLOC_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    assign bus.donor_ready   = (state_q == IDLE);
    assign bus.grant_valid   = gv_q;
    assign bus.grant_idx     = gidx_q;
    assign bus.nomatch       = nm_q;
    assign bus.pending       = pend_q;
    assign bus.units_granted = units_q;
endmodule

// File: tb/tb_donation_allocator.sv
// Bench for donation_allocator: a transaction-level reference model plus directed donors.
// Build with ALLOC_ROUND_ROBIN_EN to match a round-robin design build.
module tb_donation_allocator;
`ifdef ALLOC_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    donation_allocator_if #(.CNT_W(8)) bus ();
    donation_allocator #(.NPAT(8), .CNT_W(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: decides each donor's outcome when it is accepted,
    // then replays the result after the matching number of examined slots.
    bit [7:0] m_pend, ma, mb, mrh, m_clr;
    bit       m_gv, m_nm, m_ready, m_hit, m_gvp, m_nmp;
    bit [2:0] m_gidx, m_idx, m_last;
    int       m_wait, m_units, m_start, m_p;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend = '0; ma = '0; mb = '0; mrh = '0;
            m_gv = 0; m_nm = 0; m_ready = 1; m_hit = 0;
            m_gidx = 0; m_idx = 0; m_last = 0;
            m_wait = 0; m_units = 0;
        end else begin
            m_gvp = m_gv;
            m_nmp = m_nm;
            m_gv = 0;
            m_nm = 0;
            m_clr = '0;
            if (m_gvp) begin
                m_clr[m_gidx] = 1'b1;
                if (m_units < 255) m_units++;
                m_last = m_gidx;
            end
            if (bus.cfg_we) begin
                ma[bus.cfg_idx]  = bus.cfg_a;
                mb[bus.cfg_idx]  = bus.cfg_b;
                mrh[bus.cfg_idx] = bus.cfg_rh;
            end
            if (m_gvp || m_nmp) begin
                m_ready = 1;
            end else if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) begin
                    if (m_hit) begin
                        m_gv = 1;
                        m_gidx = m_idx;
                    end else begin
                        m_nm = 1;
                    end
                end
            end else if (m_ready && bus.donor_valid) begin
                m_ready = 0;
                m_hit = 0;
                m_wait = 8;
                m_start = RR ? (int'(m_last) + 7) % 8 : 7;
                for (int i = 0; i < 8; i++) begin
                    m_p = (m_start - i + 8) % 8;
                    if (!m_hit && m_pend[m_p]
                        && (!bus.donor_a || ma[m_p])
                        && (!bus.donor_b || mb[m_p])
                        && (!bus.donor_rh || mrh[m_p])) begin
                        m_hit = 1;
                        m_idx = 3'(m_p);
                        m_wait = i + 1;
                    end
                end
            end
            m_pend = ((m_pend & ~m_clr) | bus.req_set) & ~bus.req_cancel;
        end
    end

    always @(negedge clk) begin
        chk("grant_valid", bus.grant_valid, m_gv);
        chk("nomatch", bus.nomatch, m_nm);
        chk("pending", bus.pending, m_pend);
        chk("units_granted", bus.units_granted, m_units);
        chk("donor_ready", bus.donor_ready, m_ready);
        if (m_gv) chk("grant_idx", bus.grant_idx, m_gidx);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(int idx, bit a, bit b, bit rh);
        bus.cfg_we = 1'b1;
        bus.cfg_idx = 3'(idx);
        bus.cfg_a = a;
        bus.cfg_b = b;
        bus.cfg_rh = rh;
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic req(logic [7:0] s, logic [7:0] c);
        bus.req_set = s;
        bus.req_cancel = c;
        tick();
        bus.req_set = '0;
        bus.req_cancel = '0;
    endtask

    task automatic donate(string tag, bit a, bit b, bit rh, bit exp_g,
                          int exp_idx, int exp_lat,
                          logic [7:0] s = 8'h00, logic [7:0] c = 8'h00);
        int n;
        bit seen;
        bus.donor_valid = 1'b1;
        bus.donor_a = a;
        bus.donor_b = b;
        bus.donor_rh = rh;
        tick();
        bus.donor_valid = 1'b0;
        bus.donor_a = ~a;
        bus.donor_b = ~b;
        bus.donor_rh = ~rh;
        n = 0;
        seen = 0;
        while (!seen && n < 12) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            seen = bus.grant_valid | bus.nomatch;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no grant or nomatch within %0d cycles", tag, n);
            tick();
            return;
        end
        chk({tag, " latency"}, n, exp_lat);
        chk({tag, " kind"}, bus.grant_valid, exp_g);
        chk({tag, " ready low"}, bus.donor_ready, 0);
        if (exp_g) chk({tag, " idx"}, bus.grant_idx, exp_idx);
        bus.req_set = s;
        bus.req_cancel = c;
        tick();
        bus.req_set = '0;
        bus.req_cancel = '0;
        @(negedge clk);
        chk({tag, " ready back"}, bus.donor_ready, 1);
        tick();
    endtask

    initial begin
        bus.cfg_we = 0; bus.cfg_idx = 0; bus.cfg_a = 0; bus.cfg_b = 0; bus.cfg_rh = 0;
        bus.req_set = 0; bus.req_cancel = 0;
        bus.donor_valid = 0; bus.donor_a = 0; bus.donor_b = 0; bus.donor_rh = 0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset pending", bus.pending, 0);
        chk("reset units", bus.units_granted, 0);
        chk("reset ready", bus.donor_ready, 1);
        chk("reset grant_idx", bus.grant_idx, 0);
        chk("reset grant_valid", bus.grant_valid, 0);
        tick();

        cfg(3, 1, 0, 1);
        req(8'h08, 8'h00);
        donate("t1 O- to A+", 0, 0, 0, 1, 3, 5);
        chk("t1 pending", bus.pending, 8'h00);
        chk("t1 units", bus.units_granted, 1);

        cfg(7, 0, 1, 0);
        cfg(2, 1, 1, 1);
        req(8'h84, 8'h00);
        donate("t2 A+ skip B-", 1, 0, 1, 1, 2, RR ? 1 : 6);
        chk("t2 pending", bus.pending, 8'h80);
        req(8'h00, 8'h80);

        donate("t3 empty", 0, 0, 0, 0, 0, 8);

        cfg(4, 1, 0, 0);
        req(8'h10, 8'h00);
        donate("t4 Rh reject", 1, 0, 1, 0, 0, 8);
        donate("t4 A- to A-", 1, 0, 0, 1, 4, RR ? 6 : 4);

        cfg(5, 0, 0, 1);
        cfg(1, 0, 0, 1);
        req(8'h22, 8'h00);
        donate("t5 O+ grant", 0, 0, 1, 1, RR ? 1 : 5, 3, 8'h20, 8'h02);
        chk("t5 pending", bus.pending, 8'h20);
        chk("t5 units", bus.units_granted, 4);

        bus.donor_valid = 1'b1;
        bus.donor_a = 0; bus.donor_b = 0; bus.donor_rh = 0;
        tick();
        bus.donor_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort pending", bus.pending, 0);
        chk("abort units", bus.units_granted, 0);
        chk("abort ready", bus.donor_ready, 1);
        chk("abort grant", bus.grant_valid, 0);
        tick();
        rst_n = 1'b1;
        repeat (12) tick();

        cfg(5, 0, 0, 1);
        cfg(1, 0, 0, 1);
        req(8'h22, 8'h00);
        donate("t6 first", 0, 0, 1, 1, 5, 3);
        req(8'h20, 8'h00);
        donate("t6 second", 0, 0, 1, 1, RR ? 1 : 5, RR ? 4 : 3);

        req(8'h00, 8'hFF);
        for (int i = 0; i < 260; i++) begin
            req(8'h01, 8'h00);
            donate("sat", 0, 0, 0, 1, 0, (RR && i == 0) ? 1 : 8);
        end
        chk("saturated units", bus.units_granted, 255);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/donation_allocator.md
# donation_allocator

Sequential allocator that assigns each incoming donated blood unit to one of eight pending patient requests. Holds per-patient ABO/Rh type registers and a pending-request vector. On each accepted donor unit it scans patients one per cycle for a pending, compatible recipient, then pulses a grant or a no-match. It sits in front of the donor/patient compatibility datapath and serialises access to it.

## Interface
Parameters:
- NPAT, 8, number of patient slots (index width 3; only 8 is supported)
- CNT_W, 8, width of the granted-units counter

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  write patient type register cfg_idx
- cfg_idx  in  3  patient slot to configure
- cfg_a, cfg_b, cfg_rh  in  1 each  patient A antigen, B antigen, Rh+
- req_set  in  8  one-cycle pulses; set pending bit per patient
- req_cancel  in  8  one-cycle pulses; clear pending bit per patient
- donor_valid  in  1  donor unit offered
- donor_a, donor_b, donor_rh  in  1 each  donor type, sampled on acceptance
- donor_ready  out  1  high in IDLE only
- grant_valid  out  1  one-cycle pulse: unit allocated
- grant_idx  out  3  allocated patient, valid with grant_valid
- nomatch  out  1  one-cycle pulse: no compatible pending patient
- pending  out  8  current pending vector
- units_granted  out  CNT_W  saturating count of grants

## Operation
- Compatibility of donor d to patient p: (!d.a | p.a) & (!d.b | p.b) & (!d.rh | p.rh).
- States: IDLE, SCAN, GRANT, NOMATCH.
- IDLE: donor_ready=1. On donor_valid & donor_ready at an edge, latch donor type, load scan pointer with start index, clear examined-counter, go SCAN.
- SCAN: each cycle examine slot ptr using registered pending and type registers. Pending & compatible -> latch ptr into grant_idx, go GRANT. Else ptr decrements modulo 8 (0 wraps to 7), counter increments; after 8th miss go NOMATCH.
- GRANT: grant_valid=1 for this cycle; pending bit of grant_idx cleared at the exiting edge; units_granted increments, saturating at 2^CNT_W-1; go IDLE.
- NOMATCH: nomatch=1 for this cycle; go IDLE.
- Start index: 7 (fixed priority, highest index first) unless round-robin configured.
- Pending update per bit, highest precedence first: req_cancel clears; req_set sets; grant clear. A set coinciding with its own grant clear leaves the bit set.
- cfg_we is accepted in any state; a write takes effect from the next edge, so a slot written mid-scan uses its new type if examined after that edge.
- Reset: state IDLE, pending=0, all type registers 0 (O-), grant_idx=0, grant_valid=0, nomatch=0, units_granted=0, last-grant index=0, donor_ready=1.
- Reset asserted mid-scan aborts the scan; the in-flight donor unit is dropped with no grant or nomatch.

## Timing
- Acceptance at edge E0. A match on the k-th examined slot (k=1..8) makes grant_valid high in the cycle after edge E0+k. Minimum latency is 1 cycle after SCAN start; maximum is 8.
- No match: nomatch is high in the cycle after edge E0+8.
- donor_ready returns high in the cycle after the GRANT/NOMATCH cycle. Back-to-back donor throughput is therefore at most one unit per 3 cycles (match on first slot).
- All outputs are registered, except donor_ready, which decodes the state register.
- donor_a, donor_b and donor_rh are ignored except at the acceptance edge.

## Configuration
- ALLOC_ROUND_ROBIN_EN defined: the scan start index is (last granted index - 1) mod 8. The last granted index is updated on each GRANT and is 0 after reset, so the first scan starts at 7.
- ALLOC_ROUND_ROBIN_EN undefined: the scan always starts at 7 (fixed priority), and no last-grant register is built.

## Test plan
- Slot 3 configured A+ and pending; donor O- offered -> grant_valid with grant_idx=3 in the cycle after E0+5. Pending bit 3 clears; units_granted=1.
- Slot 7 B- and slot 2 AB+ both pending; donor A+ -> slot 7 skipped, grant_idx=2 in the cycle after E0+6.
- No pending bits; donor O- -> nomatch in the cycle after E0+8, no grant_valid, donor_ready high one cycle later.
- Only slot 4 pending, configured A-; donor A+ -> nomatch (Rh rejection). Same setup with donor A- -> grant_idx=4.
- Slots 5 and 1 O+ pending; donor O+ granted to slot 5. In the GRANT cycle, req_set[5] and req_cancel[1] pulse together -> pending=0x20 after the edge. Reset asserted during the next scan -> outputs and pending return to reset values, no pulse seen.
- Slots 5 and 1 O+; req_set[5] re-pulsed after first grant; second donor O+ -> grant_idx=1 with ALLOC_ROUND_ROBIN_EN defined, grant_idx=5 without it.
